// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: core (C) has priority, loader (D) gets
// starvation force-grants and lock bursts. Define DMEM_ARB_STATS_EN to add contention counters.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  input  logic        d_lock,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0] conflict_cnt,
  output logic [31:0] forced_cnt
`endif
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {S_CORE, S_DMA_LOCK} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              starved;
  logic              c_aligned, d_aligned;

  assign starved   = (wait_cnt == WAIT_W'(MAX_WAIT));
  assign c_aligned = (c_addr[1:0] == 2'b00);
  assign d_aligned = (d_addr[1:0] == 2'b00);

  // Grants are gated by rst_n so nothing reaches memory while reset is held.
  always_comb begin
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    state_nxt = state;
    if (rst_n) begin
      case (state)
        S_CORE: begin
          d_gnt = d_req && (!c_req || starved);
          c_gnt = c_req && !d_gnt;
          if (d_gnt && d_lock) state_nxt = S_DMA_LOCK;
        end
        S_DMA_LOCK: begin
          d_gnt = d_req;
          c_gnt = c_req && !d_req;
          if (!d_req || !d_lock) state_nxt = S_CORE;
        end
        default: state_nxt = S_CORE;
      endcase
    end
  end

  always_comb begin
    wait_nxt = '0;
    if (d_req && !d_gnt) wait_nxt = starved ? wait_cnt : wait_cnt + WAIT_W'(1);
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_we    = d_we && d_aligned;
    end else if (c_gnt) begin
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_we    = c_we && c_aligned;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_CORE;
      wait_cnt <= '0;
      c_rvalid <= 1'b0;
      c_rdata  <= '0;
      c_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      c_rvalid <= c_gnt;
      c_err    <= c_gnt && !c_aligned;
      c_rdata  <= (c_gnt && !c_we && c_aligned) ? mem_rdata : '0;
      d_rvalid <= d_gnt;
      d_err    <= d_gnt && !d_aligned;
      d_rdata  <= (d_gnt && !d_we && d_aligned) ? mem_rdata : '0;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // A force-grant is a D win in S_CORE while C is also asking.
  logic forced_evt;
  assign forced_evt = (state == S_CORE) && d_gnt && c_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
      forced_cnt   <= '0;
    end else begin
      if (c_req && d_req && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 32'd1;
      if (forced_evt && (forced_cnt != '1))       forced_cnt   <= forced_cnt + 32'd1;
    end
  end
`endif

endmodule
